// File: rtl/spi_pkg.sv
// Shared SPI definitions: master FSM states and the bus mode (mode 0).
// Also used by the slave-side spi_top.
package spi_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, TAIL, GAP} spi_state_t;

  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b0;

endpackage

// File: rtl/spi_clk_gen.sv
// SCK half-period timer: counts CLK_DIV cycles while enabled and strobes rise/fall alternately.
// load parks the counter at CLK_DIV with the next strobe being a rise.
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(CLK_DIV + 1);

  logic [CW-1:0] cnt;
  logic          phase;
  logic          tick;

  assign tick = en && (cnt == CW'(1));
  assign rise = tick && !phase;
  assign fall = tick && phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (load) begin
      cnt   <= CW'(CLK_DIV);
      phase <= 1'b0;
    end else if (tick) begin
      cnt   <= CW'(CLK_DIV);
      phase <= !phase;
    end else if (en) begin
      cnt   <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master: one DATA_W-bit full-duplex frame per accepted start pulse.
// Define SPI_MASTER_LSB_FIRST_EN for LSB-first transfers (default MSB-first).
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 4,
  parameter int SETUP_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              spi_sck,
  output logic              spi_ss,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int SW = $clog2(SETUP_CYC + 1);
  localparam int BW = $clog2(DATA_W + 1);

  spi_state_t        state, state_next;
  logic [SW-1:0]     setup_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shreg, shreg_next;
  logic              miso_meta, miso_sync;
  logic              gen_en, edge_lead, edge_trail, tick, sample_edge;
  logic              last_bit, first_bit, next_bit;

  assign gen_en = (state == SHIFT) || (state == TAIL) || (state == GAP);

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk  (clk),
    .rst  (rst),
    .load (!gen_en),
    .en   (gen_en),
    .rise (edge_lead),
    .fall (edge_trail)
  );

  // TAIL and GAP reuse the half-period timer for their CLK_DIV-cycle holds.
  assign tick        = edge_lead || edge_trail;
  assign sample_edge = CPHA ? edge_lead : edge_trail;
  assign last_bit    = (bit_cnt == BW'(DATA_W - 1));

`ifdef SPI_MASTER_LSB_FIRST_EN
  assign shreg_next = {miso_sync, shreg[DATA_W-1:1]};
  assign first_bit  = tx_data[0];
  assign next_bit   = shreg[1];
`else
  assign shreg_next = {shreg[DATA_W-2:0], miso_sync};
  assign first_bit  = tx_data[DATA_W-1];
  assign next_bit   = shreg[DATA_W-2];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start && !busy)             state_next = SETUP;
      SETUP: if (setup_cnt == SW'(1))        state_next = SHIFT;
      SHIFT: if (sample_edge && last_bit)    state_next = TAIL;
      TAIL:  if (tick)                       state_next = GAP;
      GAP:   if (tick)                       state_next = IDLE;
      default:                               state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      setup_cnt <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      miso_meta <= 1'b0;
      miso_sync <= 1'b0;
      rx_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      spi_sck   <= CPOL;
      spi_ss    <= 1'b1;
      spi_mosi  <= 1'b0;
    end else begin
      miso_meta <= spi_miso;
      miso_sync <= miso_meta;
      done      <= 1'b0;
      case (state)
        IDLE: if (start && !busy) begin
          shreg     <= tx_data;
          spi_mosi  <= first_bit;
          spi_ss    <= 1'b0;
          busy      <= 1'b1;
          setup_cnt <= SW'(SETUP_CYC);
          bit_cnt   <= '0;
        end
        SETUP: setup_cnt <= (setup_cnt == SW'(1)) ? SW'(SETUP_CYC) : setup_cnt - 1'b1;
        SHIFT: begin
          if (edge_lead)  spi_sck <= !CPOL;
          if (edge_trail) spi_sck <= CPOL;
          if (sample_edge) begin
            shreg   <= shreg_next;
            bit_cnt <= bit_cnt + 1'b1;
            // The last bit stays on the line through TAIL.
            if (!last_bit) spi_mosi <= next_bit;
          end
        end
        TAIL: if (tick) begin
          spi_ss  <= 1'b1;
          rx_data <= shreg;
          done    <= 1'b1;
        end
        GAP: if (tick) busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: table-driven frames, randomized slave traffic, and reset/start-timing corner cases.
// Works with or without SPI_MASTER_LSB_FIRST_EN defined.
module tb_spi_master;

  localparam int DW  = 8;
  localparam int CD  = 4;
  localparam int SC  = 2;
  localparam int LAT = 1 + SC + 2 * DW * CD + CD;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [DW-1:0] tx_data, rx_data;
  logic          busy, done, spi_sck, spi_ss, spi_mosi, spi_miso;

  int n_checks = 0;
  int n_fail   = 0;

  // miso source: 0 tied low, 1 tied high, 2 loopback, 3 slave model
  int            miso_mode = 0;
  logic [DW-1:0] slave_word = '0;
  logic          slave_bit = 1'b0;
  int            sidx = 0;
  logic          cap_bits[$];

  spi_master #(.DATA_W(DW), .CLK_DIV(CD), .SETUP_CYC(SC)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .tx_data  (tx_data),
    .rx_data  (rx_data),
    .busy     (busy),
    .done     (done),
    .spi_sck  (spi_sck),
    .spi_ss   (spi_ss),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  always #5 clk = ~clk;

  assign spi_miso = (miso_mode == 0) ? 1'b0 :
                    (miso_mode == 1) ? 1'b1 :
                    (miso_mode == 2) ? spi_mosi : slave_bit;

  // Bit i of a word in wire order.
  function automatic logic word_bit(input logic [DW-1:0] w, input int i);
    if (i < 0 || i >= DW) return 1'b0;
`ifdef SPI_MASTER_LSB_FIRST_EN
    return w[i];
`else
    return w[DW-1-i];
`endif
  endfunction

  // Reassemble the bits seen on mosi into the word the master was sending.
  function automatic logic [DW-1:0] cap_word();
    logic [DW-1:0] w = '0;
    for (int i = 0; i < cap_bits.size() && i < DW; i++) begin
`ifdef SPI_MASTER_LSB_FIRST_EN
      w[i] = cap_bits[i];
`else
      w[DW-1-i] = cap_bits[i];
`endif
    end
    return w;
  endfunction

  // Mode-0 slave: presents a bit when selected and after every falling SCK.
  always @(negedge spi_ss) begin
    sidx = 0;
    slave_bit = word_bit(slave_word, 0);
  end
  always @(negedge spi_sck) begin
    if (spi_ss === 1'b0) begin
      sidx = sidx + 1;
      slave_bit = word_bit(slave_word, sidx);
    end
  end
  always @(posedge spi_sck) begin
    if (spi_ss === 1'b0) cap_bits.push_back(spi_mosi);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge with busy low; returns at the negedge where busy has dropped.
  task automatic run_frame(input logic [DW-1:0] tx, input int mode, input logic [DW-1:0] sword,
                           input logic [DW-1:0] exp_rx, input bit inject, input bit late, input string tag);
    int   n, rises, r1, r2, done_extra, ss_low, busy_seen;
    logic prev_sck;
    bit   seen;
    miso_mode  = mode;
    slave_word = sword;
    cap_bits.delete();
    tx_data = tx;
    start   = 1'b1;
    rst     = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n = 1; rises = 0; r1 = 0; r2 = 0; seen = 0;
    check({tag, "/busy_c1"}, 32'(busy), 32'd1);
    check({tag, "/ss_c1"}, 32'(spi_ss), 32'd0);
    prev_sck = spi_sck;
    while (n < LAT + 40) begin
      if (spi_sck && !prev_sck) begin
        rises++;
        if (rises == 1) r1 = n;
        if (rises == 2) r2 = n;
      end
      prev_sck = spi_sck;
      if (done) begin seen = 1; break; end
      if (inject && n == 10) begin tx_data = 8'h3C; start = 1'b1; end
      if (inject && n == 11) start = 1'b0;
      @(negedge clk);
      n++;
    end
    check({tag, "/done_seen"}, 32'(seen), 32'd1);
    check({tag, "/latency"}, n, LAT);
    check({tag, "/sck_rises"}, rises, DW);
    check({tag, "/first_rise"}, r1, 1 + SC + CD);
    check({tag, "/sck_period"}, r2 - r1, 2 * CD);
    check({tag, "/rx_data"}, 32'(rx_data), 32'(exp_rx));
    check({tag, "/ss_at_done"}, 32'(spi_ss), 32'd1);
    check({tag, "/busy_at_done"}, 32'(busy), 32'd1);
    check({tag, "/mosi_bits"}, cap_bits.size(), DW);
    check({tag, "/mosi_word"}, 32'(cap_word()), 32'(tx));
    done_extra = 0; ss_low = 0;
    while (n < LAT + 40) begin
      @(negedge clk);
      n++;
      start = late && (n == LAT + CD - 1);
      if (done) done_extra++;
      if (!spi_ss) ss_low++;
      if (!busy) break;
    end
    start = 1'b0;
    check({tag, "/done_once"}, done_extra, 0);
    check({tag, "/ss_gap"}, ss_low, 0);
    check({tag, "/busy_fall"}, n, LAT + CD);
    check({tag, "/rx_hold"}, 32'(rx_data), 32'(exp_rx));
    if (late) begin
      busy_seen = 0;
      repeat (4) begin
        @(negedge clk);
        if (busy || !spi_ss) busy_seen++;
      end
      check({tag, "/late_start_ignored"}, busy_seen, 0);
    end
  endtask

  // Reset while SCK is high in the 4th bit; the frame must vanish without done.
  task automatic abort_frame();
    int   rises, n, dones, busys;
    logic prev_sck;
    miso_mode = 2;
    cap_bits.delete();
    tx_data = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rises = 0; n = 0;
    prev_sck = spi_sck;
    while (rises < 4 && n < LAT + 40) begin
      @(negedge clk);
      n++;
      if (spi_sck && !prev_sck) rises++;
      prev_sck = spi_sck;
    end
    check("abort/reached_bit4", rises, 4);
    #1 rst = 1'b1;
    #1;
    check("abort/ss", 32'(spi_ss), 32'd1);
    check("abort/sck", 32'(spi_sck), 32'd0);
    check("abort/busy", 32'(busy), 32'd0);
    check("abort/rx_data", 32'(rx_data), 32'd0);
    check("abort/mosi", 32'(spi_mosi), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0; busys = 0;
    repeat (LAT + 10) begin
      @(negedge clk);
      if (done) dones++;
      if (busy) busys++;
    end
    check("abort/no_done", dones, 0);
    check("abort/stays_idle", busys, 0);
  endtask

  typedef struct {
    logic [DW-1:0] tx;
    int            mode;
    logic [DW-1:0] sword;
    logic [DW-1:0] exp_rx;
    bit            inject;
    bit            late;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{8'hA5, 2, 8'h00, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 0, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[2] = '{8'hC3, 1, 8'h00, 8'hFF, 1'b0, 1'b0};
    vecs[3] = '{8'h01, 2, 8'h00, 8'h01, 1'b0, 1'b0};
    vecs[4] = '{8'h96, 2, 8'h00, 8'h96, 1'b1, 1'b0};
    vecs[5] = '{8'h5A, 3, 8'hE7, 8'hE7, 1'b0, 1'b1};

    rst = 1'b1; start = 1'b0; tx_data = '0;
    repeat (3) @(negedge clk);
    check("reset/ss", 32'(spi_ss), 32'd1);
    check("reset/sck", 32'(spi_sck), 32'd0);
    check("reset/mosi", 32'(spi_mosi), 32'd0);
    check("reset/busy", 32'(busy), 32'd0);
    check("reset/done", 32'(done), 32'd0);
    check("reset/rx_data", 32'(rx_data), 32'd0);

    // The first frame releases reset and raises start on the same edge.
    for (int i = 0; i < 6; i++)
      run_frame(vecs[i].tx, vecs[i].mode, vecs[i].sword, vecs[i].exp_rx,
                vecs[i].inject, vecs[i].late, $sformatf("vec%0d", i));

    abort_frame();

    for (int i = 0; i < 8; i++) begin
      logic [DW-1:0] t, s;
      t = DW'($urandom);
      s = DW'($urandom);
      run_frame(t, 3, s, s, 1'b0, 1'b0, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
